// File: rtl/scan_sel_gen_if.sv
// rtl/scan_sel_gen_if.sv - request/select bundle between scan_sel_gen and its driver
//
// Signals:
//   en, req[3:0], dwell[DWELL_W-1:0]          : driven by master, consumed by scan_sel_gen
//   sel_a, sel_b, sel_valid, sel_start        : driven by scan_sel_gen (slave)
interface scan_sel_gen_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic               sel_a;
    logic               sel_b;
    logic               sel_valid;
    logic               sel_start;

    modport master (
        output en, req, dwell,
        input  sel_a, sel_b, sel_valid, sel_start
    );

    modport slave (
        input  en, req, dwell,
        output sel_a, sel_b, sel_valid, sel_start
    );
endinterface

// File: rtl/scan_sel_gen.sv
// rtl/scan_sel_gen.sv - round-robin 2-bit select generator with programmable dwell
//
// Ports:
//   clk    : system clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : scan_sel_gen_if.slave (en, req, dwell in; sel_a, sel_b, sel_valid, sel_start out)
// Option macro: SCAN_GAP_CYCLE_EN inserts one invalid cycle after every grant.
module scan_sel_gen #(
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_sel_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [1:0]         ptr, ptr_n;
    logic [1:0]         ch, ch_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic               valid_q, valid_n;
    logic               start_q, start_n;
    logic               grant;
    logic [1:0]         end_ptr;
    logic [2:0]         win_now, win_end;
    logic [DWELL_W-1:0] load_cnt;

    // Returns {found, index} of the first set request at or after base, wrapping 3->0.
    // Scans from the farthest offset down so the nearest hit is the one kept.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign end_ptr  = ch + 2'd1;
    assign win_now  = pick(bus.req, ptr);
    assign win_end  = pick(bus.req, end_ptr);
    assign load_cnt = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= 2'd0;
            ch      <= 2'd0;
            cnt     <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            ch      <= ch_n;
            cnt     <= cnt_n;
            valid_q <= valid_n;
            start_q <= start_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        ch_n    = ch;
        cnt_n   = cnt;
        grant   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.en && win_now[2]) begin
                    grant = 1'b1;
                    ch_n  = win_now[1:0];
                end
            end
            ST_HOLD: begin
                if (cnt <= DWELL_W'(1)) begin
                    // Grant completed: priority always moves past the served channel,
                    // even if en dropped on this same edge.
                    ptr_n   = end_ptr;
                    state_n = ST_IDLE;
`ifdef SCAN_GAP_CYCLE_EN
                    if (bus.en) state_n = ST_GAP;
`else
                    if (bus.en && win_end[2]) begin
                        grant = 1'b1;
                        ch_n  = win_end[1:0];
                    end
`endif
                end else if (!bus.en) begin
                    // Abort: ptr untouched so the interrupted channel is served first again.
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - DWELL_W'(1);
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
                if (bus.en && win_now[2]) begin
                    grant = 1'b1;
                    ch_n  = win_now[1:0];
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (grant) begin
            state_n = ST_HOLD;
            cnt_n   = load_cnt;
        end
    end

    always_comb begin
        valid_n = (state_n == ST_HOLD);
        start_n = grant;
    end

    assign bus.sel_a     = ch[1];
    assign bus.sel_b     = ch[0];
    assign bus.sel_valid = valid_q;
    assign bus.sel_start = start_q;
endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Round-robin select generator that sits directly upstream of the 2-to-4 decoder.
- Arbitrates among 4 request lines and drives the decoder's 2-bit select (sel_a = MSB, sel_b = LSB).
- Holds each grant for a programmable dwell time.
- Typical use: digit/row scanning where the decoder output enables one of 4 loads at a time.

Parameters:
- DWELL_W, 8, width of dwell count input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; low forces idle.
- req  input  4  request per channel; req[i] = channel i wants a slot.
- dwell  input  DWELL_W  grant length in cycles; sampled at grant start; 0 treated as 1.
- sel_a  output  1  select MSB to decoder A input.
- sel_b  output  1  select LSB to decoder B input.
- sel_valid  output  1  high while a grant is active (decoder output meaningful).
- sel_start  output  1  one-cycle pulse on first cycle of each grant.

Behaviour:
- Reset (rst_n low, async): sel_a=0, sel_b=0, sel_valid=0, sel_start=0, state=IDLE, ptr=0, cnt=0. Clean restart on release regardless of prior state.
- Registered outputs; channel index ch = {sel_a, sel_b}.
- Arbitration (combinational, used at decision edges):
  - Search req starting at ptr, wrapping 3->0.
  - Pick the first set bit; ptr = highest-priority position.
- IDLE: sel_valid=0, sel_start=0, sel_a/sel_b hold last value.
  - If en=1 and req!=0 at an edge: load ch=winner, cnt = (dwell==0 ? 1 : dwell), sel_valid=1, sel_start=1, go HOLD.
  - Latency from req/en seen to sel_valid high: 1 cycle.
- HOLD: sel_start=0 after the first cycle; cnt decrements each edge.
  - Grant lasts exactly N = max(dwell,1) cycles of sel_valid.
  - On the edge where cnt==1 (grant end), ptr = ch+1 mod 4.
  - If en=1 and req (re-evaluated with new ptr) != 0: immediate back-to-back grant on same edge, no bubble; sel_start=1 again, cnt reloaded.
  - Otherwise: sel_valid=0, go IDLE.
- Non-preemptive: dropping req[ch] mid-grant does not shorten it. New requests are considered only at grant end.
- Single requester: the same channel is re-granted repeatedly with no gap.
- en low in HOLD: next edge sel_valid=0, sel_start=0, go IDLE, ptr unchanged (aborted channel keeps priority).
- dwell changes mid-grant: ignored until next grant start.
- Counter never wraps; max grant = 2^DWELL_W - 1 cycles.

Optional Feature:
- Macro SCAN_GAP_CYCLE_EN.
- Defined:
  - Every grant end passes through a one-cycle GAP state (sel_valid=0, sel_start=0, sel_a/sel_b hold) before any next grant, including a re-grant of the same channel.
  - Back-to-back grants are separated by exactly 1 invalid cycle (break-before-make for driven loads).
  - en low in GAP goes to IDLE.
- Undefined: no GAP state; back-to-back grants as described in Behaviour.

Test Plan:
- Reset/idle: rst_n low, then high with en=1, req=0000 -> sel_valid=0, sel_start=0, {sel_a,sel_b}=00 indefinitely.
- Single grant: en=1, dwell=3, req=0100 from cycle 0 -> sel_valid high cycles 1-3, ch=10, sel_start only cycle 1; re-grant ch=10 at cycle 4 with sel_start=1 (macro off).
- Round robin: req=1111, dwell=2 -> ch sequence 00,01,10,11,00 each for 2 cycles, no gaps; with SCAN_GAP_CYCLE_EN, one sel_valid=0 cycle between each.
- Dwell zero/non-preempt: dwell=0, req=0011 -> grants alternate 00,01 every cycle. Then dwell=5 with req[ch] dropped at cycle 2 of grant -> grant still lasts 5 cycles.
- Abort: req=1010, dwell=4, en low during cycle 2 of grant to ch=01 -> sel_valid low next cycle. en high again -> ch=01 granted again (ptr unchanged).
- Async reset mid-grant: rst_n pulled low between clock edges during HOLD -> all outputs 0 immediately, without waiting for an edge. After release, first grant starts from ptr=0.
